// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Ticks per bit period and the tick index of the middle of the start bit.
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // XOR-reduction of a byte; used for parity generation and checking.
  function automatic logic byte_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so a released reset never looks like a falling edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start + DBIT data (+ optional parity) + stop frames
// from rx using the shared 16x oversampling tick.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit, the
// PARITY_ODD parameter and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] MID       = 5'(MID_TICK);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  uart_state_t       state;
  logic              armed;
  logic [4:0]        s_reg;
  logic [2:0]        n_reg;
  logic [DBIT-1:0]   b_reg;
  logic              rx_s;
`ifdef UART_RX_PARITY_EN
  logic              p_bit;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM with registered data/status outputs and a one-cycle done strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_bit        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A low line only starts a frame once the line has been seen high,
          // so a held break produces a single frame.
          if (armed && !rx_s) begin
            state <= ST_START;
            s_reg <= '0;
            armed <= 1'b0;
          end else if (rx_s) begin
            armed <= 1'b1;
          end
        end

        ST_START: begin
          if (s_tick) begin
            if (s_reg == MID) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s_reg <= '0;
                n_reg <= '0;
              end else begin
                // Start bit gone by mid-bit: treat as a glitch.
                state <= ST_IDLE;
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (s_tick) begin
            if (s_reg == LAST_TICK) begin
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              s_reg <= '0;
              if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                n_reg <= n_reg + 3'd1;
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s_reg == LAST_TICK) begin
              p_bit <= rx_s;
              s_reg <= '0;
              state <= ST_STOP;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (s_tick) begin
            if (s_reg == STOP_LAST) begin
              state        <= ST_IDLE;
              rx_done_tick <= 1'b1;
              dout         <= 8'(b_reg);
              frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err   <= (byte_parity(8'(b_reg)) ^ p_bit) != PARITY_ODD;
`endif
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus random frames, checked
// against a queue of expected frames built from the bits the bench sends.
module tb_uart_rx;

  localparam int  TDIV       = 4;            // clk cycles per s_tick
  localparam int  BT         = 16 * TDIV;    // clk cycles per bit
  localparam bit  PARITY_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  int tick_cnt = 0;

  // Captured and expected frames: {parity_err, frame_err, dout}.
  logic [9:0] cap_q[$];
  logic [9:0] exp_q[$];

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD (PARITY_ODD)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Baud tick: one clk pulse every TDIV cycles, changed away from posedge.
  always @(negedge clk) begin
    tick_cnt = (tick_cnt == TDIV - 1) ? 0 : tick_cnt + 1;
    s_tick   = (tick_cnt == 0);
  end

  // Record every done strobe with the outputs presented alongside it.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
`ifdef UART_RX_PARITY_EN
      cap_q.push_back({parity_err, frame_err, dout});
`else
      cap_q.push_back({1'b0, frame_err, dout});
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BT);
  endtask

  // Serialize one frame LSB first and record what the receiver must report.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic pflip);
    logic perr;
    perr = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ PARITY_ODD ^ pflip);
    perr = pflip;
`endif
    send_bit(stop);
    exp_q.push_back({perr, ~stop, data});
  endtask

  // Compare captured strobes against the expected frames, then clear both.
  task automatic check_frames(input string tag);
    int n;
    check({tag, "_strobes"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_frame%0d", tag, i), cap_q[i], exp_q[i]);
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       pf;
    int         gap;

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(4);
    check("rst_dout", dout, 8'h00);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    wait_clks(BT);
    check("idle_no_strobe", cap_q.size(), 0);

    // Single clean frame
    send_frame(8'h55, 1'b1, 1'b0);
    wait_clks(BT);
    check_frames("f55");

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    wait_clks(BT);
    check_frames("b2b");

    // Short low glitch on the line
    rx = 1'b0;
    wait_clks(4 * TDIV);
    rx = 1'b1;
    wait_clks(2 * BT);
    check_frames("glitch");
    check("glitch_dout", dout, 8'h0F);
    check("glitch_ferr", frame_err, 1'b0);

    // Framing error followed by a held break
    send_frame(8'h80, 1'b0, 1'b0);
    wait_clks(3 * BT);
    check_frames("break");
    rx = 1'b1;
    wait_clks(BT);
    check("break_hold_dout", dout, 8'h80);
    check("break_hold_ferr", frame_err, 1'b1);
    check("break_no_more", cap_q.size(), 0);

    // Reset in the middle of the data bits
    d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    check("midrst_dout", dout, 8'h00);
    check("midrst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    wait_clks(2 * BT);
    check_frames("midrst");
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_clks(BT);
    check_frames("after_rst");

`ifdef UART_RX_PARITY_EN
    // Parity checking: 0x07 has odd weight, so parity bit 0 is wrong under even parity
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(BT);
    check_frames("parity");
`endif

    // Random frames, random gaps, occasional framing errors
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pf   = 1'($urandom);
      send_frame(d, stop, pf);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      for (int g = 0; g < gap; g++) send_bit(1'b1);
    end
    rx = 1'b1;
    wait_clks(BT);
    check_frames("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
